// File: rtl/p_reg3_xfer.sv
// p_reg3_xfer: parasite-side block-transfer engine for the register-3
// host-to-parasite FIFO. It drains the FIFO one or two bytes per transfer
// using single-cycle read selects, packs the bytes into 16-bit words on a
// valid/ready stream, and counts a programmed byte length down to zero.
//
// Optional build macro: P_REG3_XFER_NMI_EN adds the active-low p_nmi_b
// output. It pulses low while the engine is reading, so that
// software-driven FIFO accesses can interleave with the engine.
module p_reg3_xfer #(
  parameter int COUNT_W = 16
) (
  input  logic               p_phi2,
  input  logic               h_rst_b,
  input  logic               start,
  input  logic               abort,
  input  logic [COUNT_W-1:0] len,
  input  logic               one_byte_mode,
  input  logic [7:0]         r3_data,
  input  logic               r3_data_available,
  input  logic               r3_two_bytes_available,
  output logic               r3_select,
  output logic               r3_rdnw,
  output logic [15:0]        m_data,
  output logic               m_bytes,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               busy,
  output logic               done,
`ifdef P_REG3_XFER_NMI_EN
  output logic               p_nmi_b,
`endif
  output logic [COUNT_W-1:0] remaining
);

  // FSM encoding. The explicit 3-bit constants keep the encoding
  // compatible with older tool flows.
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_RD0  = 3'd2;
  localparam logic [2:0] ST_RD1  = 3'd3;
  localparam logic [2:0] ST_PUSH = 3'd4;

  logic [2:0]         state_reg, state_next;
  logic               mode_reg;
  logic [COUNT_W-1:0] remaining_reg;
  logic [15:0]        m_data_reg;
  logic               m_bytes_reg;
  logic               done_reg;

  logic               single_rd;
  logic               rd_cond;
  logic               start_ok;
  logic [COUNT_W-1:0] dec_amt;
  logic [COUNT_W-1:0] rem_after;

  // Take a single byte when the engine is in one-byte mode, or when only
  // one byte is left. A two-byte read therefore never runs past the
  // programmed length, and the remaining count cannot underflow.
  assign single_rd = mode_reg || (remaining_reg == COUNT_W'(1));
  assign rd_cond   = single_rd ? r3_data_available : r3_two_bytes_available;
  assign start_ok  = start && (len != '0);
  assign dec_amt   = m_bytes_reg ? COUNT_W'(1) : COUNT_W'(2);
  assign rem_after = remaining_reg - dec_amt;

  // Next-state logic. abort overrides every other input.
  always_comb begin
    state_next = state_reg;
    if (abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: if (start_ok) state_next = ST_WAIT;
        ST_WAIT: if (rd_cond) state_next = ST_RD0;
        ST_RD0:  state_next = single_rd ? ST_PUSH : ST_RD1;
        ST_RD1:  state_next = ST_PUSH;
        ST_PUSH: begin
          if (m_ready) begin
            state_next = (rem_after == '0) ? ST_IDLE : ST_WAIT;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge p_phi2 or negedge h_rst_b) begin
    if (!h_rst_b) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath: length counter, latched mode, word packing and done pulse.
  // If abort arrives in RD0, the FIFO still sees that cycle's select, but
  // the byte is discarded because abort blocks the capture.
  always_ff @(posedge p_phi2 or negedge h_rst_b) begin
    if (!h_rst_b) begin
      mode_reg      <= 1'b0;
      remaining_reg <= '0;
      m_data_reg    <= 16'h0000;
      m_bytes_reg   <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (abort) begin
        remaining_reg <= '0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (start) begin
              if (len != '0) begin
                remaining_reg <= len;
                mode_reg      <= one_byte_mode;
              end else begin
                done_reg <= 1'b1;
              end
            end
          end
          ST_RD0: begin
            m_data_reg[7:0] <= r3_data;
            if (single_rd) begin
              m_data_reg[15:8] <= 8'h00;
              m_bytes_reg      <= 1'b1;
            end else begin
              m_bytes_reg <= 1'b0;
            end
          end
          ST_RD1: begin
            m_data_reg[15:8] <= r3_data;
          end
          ST_PUSH: begin
            if (m_ready) begin
              remaining_reg <= rem_after;
              if (rem_after == '0) begin
                done_reg <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef P_REG3_XFER_NMI_EN
  logic nmi_b_reg;

  // The NMI goes low for the cycle after the read condition is seen in
  // WAIT, which is the RD0 cycle. It returns high on the following edge.
  // abort and reset force it high.
  always_ff @(posedge p_phi2 or negedge h_rst_b) begin
    if (!h_rst_b) begin
      nmi_b_reg <= 1'b1;
    end else if (abort) begin
      nmi_b_reg <= 1'b1;
    end else begin
      nmi_b_reg <= !((state_reg == ST_WAIT) && rd_cond);
    end
  end

  assign p_nmi_b = nmi_b_reg;
`endif

  // Outputs are decoded from the state, so an asynchronous reset clears
  // them at once.
  assign r3_select = (state_reg == ST_RD0) || (state_reg == ST_RD1);
  assign r3_rdnw   = 1'b1;
  assign m_valid   = (state_reg == ST_PUSH);
  assign busy      = (state_reg != ST_IDLE);
  assign m_data    = m_data_reg;
  assign m_bytes   = m_bytes_reg;
  assign done      = done_reg;
  assign remaining = remaining_reg;

endmodule
